// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Host byte channel feeding the instruction-memory loader.
//   s_valid : host byte valid (host -> loader)
//   s_data  : host byte       (host -> loader)
//   s_ready : loader can take a byte (loader -> host)
// A byte transfers on a rising edge where s_valid && s_ready.
// Modports: master = host side, slave = loader side.
// -----------------------------------------------------------------------------
interface imem_loader_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program image over a byte channel, writes it word by word into
// the instruction memory and holds the core in reset until the whole image
// has arrived with a matching XOR checksum.
// Frame: count_lo, count_hi (word count N, LE), 4*N data bytes (LE words),
//        one checksum byte = XOR of every preceding frame byte.
// Ports:
//   i_clk        : clock, rising edge
//   i_reset      : synchronous active-high reset
//   i_start      : one-cycle pulse arming a load (honoured in idle/done/error)
//   io_host      : byte channel (slave side), s_ready is registered
//   o_imem_we    : one-cycle imem write strobe
//   o_imem_addr  : imem word address
//   o_imem_wdata : assembled 32-bit word
//   o_core_hold  : 1 keeps the core in reset
//   o_done       : image loaded and verified
//   o_error      : load aborted (oversize count or checksum mismatch)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   imem_loader_if.slave  io_host,
   output logic          o_imem_we,
   output logic [AW-1:0] o_imem_addr,
   output logic [31:0]   o_imem_wdata,
   output logic          o_core_hold,
   output logic          o_done,
   output logic          o_error
);

   localparam logic [15:0] DepthW = 16'(DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StCntLo,
      StCntHi,
      StData,
      StCsum,
      StDone,
      StErr
   } state_e;

   state_e        r_state;
   logic          r_ready;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic          r_hold;
   logic          r_done;
   logic          r_error;
   logic [7:0]    r_xor;
   logic [1:0]    r_byte_idx;
   // One bit wider than the address so N == DEPTH ends without wrapping.
   logic [AW:0]   r_word_idx;
   logic [15:0]   r_count;
   // Bytes 0..2 of the word in flight; byte 0 ends up in bits 7:0.
   logic [23:0]   r_shift;

   logic          w_fire;
   logic [15:0]   w_count;
   logic [AW:0]   w_word_next;
   logic          w_last_word;

   assign w_fire      = io_host.s_valid & r_ready;
   assign w_count     = {io_host.s_data, r_count[7:0]};
   assign w_word_next = r_word_idx + 1'b1;
   assign w_last_word = ({{(15 - AW){1'b0}}, w_word_next} == r_count);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_ready    <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_hold     <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_xor      <= '0;
         r_byte_idx <= '0;
         r_word_idx <= '0;
         r_count    <= '0;
         r_shift    <= '0;
      end else begin
         r_we <= 1'b0;
         unique case (r_state)
            StIdle, StDone, StErr: begin
               if (i_start) begin
                  r_state    <= StCntLo;
                  r_ready    <= 1'b1;
                  r_hold     <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_xor      <= '0;
                  r_byte_idx <= '0;
                  r_word_idx <= '0;
               end
            end

            StCntLo: begin
               if (w_fire) begin
                  r_count[7:0] <= io_host.s_data;
                  r_xor        <= r_xor ^ io_host.s_data;
                  r_state      <= StCntHi;
               end
            end

            StCntHi: begin
               if (w_fire) begin
                  r_count[15:8] <= io_host.s_data;
                  r_xor         <= r_xor ^ io_host.s_data;
                  if (w_count > DepthW) begin
                     r_state <= StErr;
                     r_ready <= 1'b0;
                     r_error <= 1'b1;
                     r_hold  <= 1'b1;
                  end else if (w_count == 16'd0) begin
                     r_state <= StCsum;
                  end else begin
                     r_state <= StData;
                  end
               end
            end

            StData: begin
               if (w_fire) begin
                  r_xor      <= r_xor ^ io_host.s_data;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_we       <= 1'b1;
                     r_addr     <= r_word_idx[AW-1:0];
                     r_wdata    <= {io_host.s_data, r_shift};
                     r_word_idx <= w_word_next;
                     if (w_last_word) begin
                        r_state <= StCsum;
                     end
                  end else begin
                     r_shift <= {io_host.s_data, r_shift[23:8]};
                  end
               end
            end

            StCsum: begin
               if (w_fire) begin
                  r_ready <= 1'b0;
                  if (io_host.s_data == r_xor) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
                  end else begin
                     r_state <= StErr;
                     r_error <= 1'b1;
                     r_hold  <= 1'b1;
                  end
               end
            end

            default: begin
               r_state <= StIdle;
               r_ready <= 1'b0;
               r_hold  <= 1'b1;
               r_done  <= 1'b0;
               r_error <= 1'b0;
            end
         endcase
      end
   end

   assign io_host.s_ready = r_ready;
   assign o_imem_we       = r_we;
   assign o_imem_addr     = r_addr;
   assign o_imem_wdata    = r_wdata;
   assign o_core_hold     = r_hold;
   assign o_done          = r_done;
   assign o_error         = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. Expected imem writes are queued as frames
// are driven and popped by a monitor whenever the loader strobes a write.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic          clk;
   logic          reset;
   logic          start;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_hold;
   logic          done;
   logic          error;

   int n_checks = 0;
   int n_errors = 0;

   logic [37:0] exp_q[$];

   imem_loader_if u_if ();

   imem_loader #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_start      (start),
      .io_host      (u_if),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_wdata (imem_wdata),
      .o_core_hold  (core_hold),
      .o_done       (done),
      .o_error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {31'd0, imem_we}, 32'd0);
         end else begin
            logic [37:0] e;
            e = exp_q.pop_front();
            check("write_addr", {26'd0, imem_addr}, {26'd0, e[37:32]});
            check("write_data", imem_wdata, e[31:0]);
         end
      end
      if (done === 1'b1 && error === 1'b1) begin
         check("done_error_exclusive", {31'd0, done & error}, 32'd0);
      end
   end

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      repeat (gap) @(negedge clk);
      u_if.s_valid = 1'b1;
      u_if.s_data  = b;
      waited = 0;
      while (u_if.s_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (u_if.s_ready !== 1'b1) begin
         check("byte_accept_timeout", {31'd0, u_if.s_ready}, 32'd1);
      end
      @(negedge clk);
      u_if.s_valid = 1'b0;
      u_if.s_data  = 8'hxx;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {31'd0, u_if.s_ready}, 32'd0);
      check({tag, "_we"},    {31'd0, imem_we},      32'd0);
      check({tag, "_addr"},  {26'd0, imem_addr},    32'd0);
      check({tag, "_wdata"}, imem_wdata,            32'd0);
      check({tag, "_hold"},  {31'd0, core_hold},    32'd1);
      check({tag, "_done"},  {31'd0, done},         32'd0);
      check({tag, "_error"}, {31'd0, error},        32'd0);
   endtask

   initial begin
      logic [7:0] good[11];
      logic [7:0] bad_csum[11];
      logic [7:0] one_word[7];
      good     = '{8'h02, 8'h00, 8'h93, 8'h80, 8'hF0, 8'h3F, 8'h93, 8'h01, 8'h11, 8'h00, 8'h5D};
      bad_csum = '{8'h02, 8'h00, 8'h93, 8'h80, 8'hF0, 8'h3F, 8'h93, 8'h01, 8'h11, 8'h00, 8'h5C};
      one_word = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};

      reset        = 1'b1;
      start        = 1'b0;
      u_if.s_valid = 1'b0;
      u_if.s_data  = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("reset");

      // Good load, N=2, continuous valid.
      pulse_start();
      check("arm_ready", {31'd0, u_if.s_ready}, 32'd1);
      exp_q.push_back({6'd0, 32'h3ff08093});
      exp_q.push_back({6'd1, 32'h00110193});
      foreach (good[i]) send_byte(good[i], 0);
      check("good_done",  {31'd0, done},         32'd1);
      check("good_hold",  {31'd0, core_hold},    32'd0);
      check("good_error", {31'd0, error},        32'd0);
      check("good_ready", {31'd0, u_if.s_ready}, 32'd0);

      // Same frame, wrong checksum; restart from DONE.
      pulse_start();
      check("rearm_done", {31'd0, done},         32'd0);
      check("rearm_hold", {31'd0, core_hold},    32'd1);
      check("rearm_ready", {31'd0, u_if.s_ready}, 32'd1);
      exp_q.push_back({6'd0, 32'h3ff08093});
      exp_q.push_back({6'd1, 32'h00110193});
      foreach (bad_csum[i]) send_byte(bad_csum[i], 0);
      check("badcs_error", {31'd0, error},        32'd1);
      check("badcs_done",  {31'd0, done},         32'd0);
      check("badcs_hold",  {31'd0, core_hold},    32'd1);
      check("badcs_ready", {31'd0, u_if.s_ready}, 32'd0);

      // Empty image.
      pulse_start();
      check("empty_arm_error", {31'd0, error}, 32'd0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("empty_done", {31'd0, done},      32'd1);
      check("empty_hold", {31'd0, core_hold}, 32'd0);
      pulse_start();
      check("empty_rearm_done",  {31'd0, done},         32'd0);
      check("empty_rearm_hold",  {31'd0, core_hold},    32'd1);
      check("empty_rearm_ready", {31'd0, u_if.s_ready}, 32'd1);

      // Oversize count (N = 65) on the already armed load.
      send_byte(8'h41, 0);
      send_byte(8'h00, 0);
      check("over_error", {31'd0, error},        32'd1);
      check("over_ready", {31'd0, u_if.s_ready}, 32'd0);
      u_if.s_valid = 1'b1;
      u_if.s_data  = 8'hAA;
      repeat (4) begin
         @(negedge clk);
         check("over_no_accept", {31'd0, u_if.s_ready}, 32'd0);
      end
      u_if.s_valid = 1'b0;
      check("over_still_error", {31'd0, error}, 32'd1);

      // Single word with random idle gaps.
      pulse_start();
      exp_q.push_back({6'd0, 32'h00000013});
      foreach (one_word[i]) send_byte(one_word[i], int'($urandom_range(3, 0)));
      check("gap_done",  {31'd0, done},  32'd1);
      check("gap_error", {31'd0, error}, 32'd0);

      // Reset after six bytes, then a complete reload.
      pulse_start();
      exp_q.push_back({6'd0, 32'h3ff08093});
      for (int i = 0; i < 6; i++) send_byte(good[i], 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("midreset");
      pulse_start();
      exp_q.push_back({6'd0, 32'h3ff08093});
      exp_q.push_back({6'd1, 32'h00110193});
      foreach (good[i]) send_byte(good[i], 0);
      check("reload_done", {31'd0, done},      32'd1);
      check("reload_hold", {31'd0, core_hold}, 32'd0);

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
